// File: rtl/sme_param_if.sv
// Host-side bus of the string-match engine: character stream in, search result out.
interface sme_param_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IDX_W = 5
);
  logic [DW-1:0]    chardata;
  logic             isstring;
  logic             ispattern;
  logic             nocase;
  logic             busy;
  logic             valid;
  logic             match;
  logic [IDX_W-1:0] match_index;

  modport master (
    output chardata, isstring, ispattern, nocase,
    input  busy, valid, match, match_index
  );

  modport slave (
    input  chardata, isstring, ispattern, nocase,
    output busy, valid, match, match_index
  );
endinterface

// File: rtl/sme_param.sv
// Parametrised string-match engine: retains a string, then searches it for each
// streamed pattern ('.', '^', '$' supported) one character compare per cycle.
module sme_param #(
  parameter int unsigned DW      = 8,
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned IDX_W   = $clog2(STR_MAX)
) (
  input  logic        clk,
  input  logic        reset,
  sme_param_if.slave  bus
);

  localparam int unsigned SIW = $clog2(STR_MAX);
  localparam int unsigned PIW = $clog2(PAT_MAX);
  localparam int unsigned SLW = $clog2(STR_MAX + 1);
  localparam int unsigned PLW = $clog2(PAT_MAX + 1);
  localparam int unsigned SW  = SLW + 1;

  localparam logic [DW-1:0] C_DOT    = DW'(8'h2E);
  localparam logic [DW-1:0] C_CARET  = DW'(8'h5E);
  localparam logic [DW-1:0] C_DOLLAR = DW'(8'h24);
  localparam logic [DW-1:0] C_SPACE  = DW'(8'h20);

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    str_buf_q [STR_MAX];
  logic [DW-1:0]    str_buf_d [STR_MAX];
  logic [DW-1:0]    pat_buf_q [PAT_MAX];
  logic [DW-1:0]    pat_buf_d [PAT_MAX];
  logic [SLW-1:0]   str_len_q, str_len_d;
  logic [PLW-1:0]   pat_len_q, pat_len_d;
  logic             str_prev_q, str_prev_d;
  logic             pat_prev_q, pat_prev_d;
  logic             nocase_q, nocase_d;
  logic [SW-1:0]    s_q, s_d;
  logic [PLW-1:0]   j_q, j_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             accept;
  logic [SLW-1:0]   str_base;
  logic [PLW-1:0]   pat_base;
  logic             head, tail;
  logic [PLW-1:0]   k;
  logic [31:0]      sk;
  logic [DW-1:0]    str_c, pat_c, prev_c, next_c;
  logic             head_ok, tail_ok;

  function automatic logic is_letter(input logic [DW-1:0] c);
    return ((c >= DW'(8'h41)) && (c <= DW'(8'h5A))) ||
           ((c >= DW'(8'h61)) && (c <= DW'(8'h7A)));
  endfunction

  function automatic logic char_match(input logic [DW-1:0] a, input logic [DW-1:0] p,
                                      input logic nc);
    return (a == p) || (p == C_DOT) ||
           (nc && is_letter(a) && is_letter(p) && ((a ^ p) == C_SPACE));
  endfunction

  // A write restarts at index 0 when the previous cycle did not load the same buffer.
  assign accept   = (state_q == IDLE) || (state_q == LOAD_STR) || (state_q == LOAD_PAT);
  assign str_base = str_prev_q ? str_len_q : '0;
  assign pat_base = pat_prev_q ? pat_len_q : '0;

  // Anchor stripping and per-cycle operand selection.
  always_comb begin
    head    = (pat_len_q != '0) && (pat_buf_q[0] == C_CARET);
    tail    = (pat_len_q > PLW'(head)) &&
              (pat_buf_q[PIW'(pat_len_q - PLW'(1))] == C_DOLLAR);
    k       = pat_len_q - PLW'(head) - PLW'(tail);
    sk      = 32'(s_q) + 32'(k);
    str_c   = str_buf_q[SIW'(32'(s_q) + 32'(j_q))];
    pat_c   = pat_buf_q[PIW'(32'(j_q) + 32'(head))];
    prev_c  = str_buf_q[SIW'(32'(s_q) - 32'd1)];
    next_c  = str_buf_q[SIW'(sk)];
    head_ok = !head || (s_q == '0) || (prev_c == C_SPACE);
    tail_ok = !tail || (sk == 32'(str_len_q)) || (next_c == C_SPACE);
  end

  always_comb begin
    state_d    = state_q;
    str_buf_d  = str_buf_q;
    pat_buf_d  = pat_buf_q;
    str_len_d  = str_len_q;
    pat_len_d  = pat_len_q;
    nocase_d   = nocase_q;
    s_d        = s_q;
    j_d        = j_q;
    busy_d     = 1'b0;
    valid_d    = 1'b0;
    match_d    = match_q;
    idx_d      = idx_q;
    str_prev_d = accept && bus.isstring;
    pat_prev_d = accept && bus.ispattern && !bus.isstring;

    // Buffer loading; isstring has priority over ispattern.
    if (accept && bus.isstring) begin
      str_len_d = str_base;
      if (str_base < SLW'(STR_MAX)) begin
        str_buf_d[SIW'(str_base)] = bus.chardata;
        str_len_d                 = str_base + SLW'(1);
      end
    end else if (accept && bus.ispattern) begin
      pat_len_d = pat_base;
      if (!pat_prev_q) nocase_d = bus.nocase;
      if (pat_base < PLW'(PAT_MAX)) begin
        pat_buf_d[PIW'(pat_base)] = bus.chardata;
        pat_len_d                 = pat_base + PLW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.isstring)       state_d = LOAD_STR;
        else if (bus.ispattern) state_d = LOAD_PAT;
      end
      LOAD_STR: begin
        if (!bus.isstring && bus.ispattern) state_d = LOAD_PAT;
      end
      LOAD_PAT: begin
        if (bus.isstring) begin
          state_d = LOAD_STR;
        end else if (!bus.ispattern) begin
          state_d = SEARCH;
          s_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
        end
      end
      SEARCH: begin
        busy_d = 1'b1;
        if ((str_len_q == '0) || (sk > 32'(str_len_q))) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          match_d = 1'b0;
          idx_d   = '0;
        end else if (j_q == k) begin
          if (head_ok && tail_ok) begin
            state_d = DONE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            match_d = 1'b1;
            idx_d   = IDX_W'(s_q);
          end else begin
            s_d = s_q + SW'(1);
            j_d = '0;
          end
        end else if (char_match(str_c, pat_c, nocase_q)) begin
          j_d = j_q + PLW'(1);
        end else begin
          s_d = s_q + SW'(1);
          j_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      str_buf_q  <= '{default: '0};
      pat_buf_q  <= '{default: '0};
      str_len_q  <= '0;
      pat_len_q  <= '0;
      str_prev_q <= 1'b0;
      pat_prev_q <= 1'b0;
      nocase_q   <= 1'b0;
      s_q        <= '0;
      j_q        <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      match_q    <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      str_buf_q  <= str_buf_d;
      pat_buf_q  <= pat_buf_d;
      str_len_q  <= str_len_d;
      pat_len_q  <= pat_len_d;
      str_prev_q <= str_prev_d;
      pat_prev_q <= pat_prev_d;
      nocase_q   <= nocase_d;
      s_q        <= s_d;
      j_q        <= j_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      match_q    <= match_d;
      idx_q      <= idx_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.valid       = valid_q;
  assign bus.match       = match_q;
  assign bus.match_index = idx_q;

endmodule

// File: tb/tb_sme_param.sv
// Directed bench for sme_param: vector table of string/pattern searches plus
// hand-written busy-ignore, saturation and mid-search reset sequences.
module tb_sme_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sme_param_if #(.DW(8), .IDX_W(5)) bus ();
  sme_param dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [95:0] s;
    logic [63:0] p;
    bit          nc;
    int          em;
    int          ei;
    int          lat;
  } vec_t;

  vec_t vt [10];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic idle_inputs();
    bus.chardata  = 8'h00;
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;
    bus.nocase    = 1'b0;
  endtask

  // Streams the non-zero bytes of v, MSB first, one per cycle.
  task automatic send(input logic [95:0] v, input bit is_str, input bit nc);
    for (int i = 11; i >= 0; i--) begin
      logic [7:0] c;
      c = v[i*8 +: 8];
      if (c != 8'h00) begin
        bus.chardata  = c;
        bus.isstring  = is_str;
        bus.ispattern = !is_str;
        bus.nocase    = nc;
        @(posedge clk); #1;
      end
    end
    idle_inputs();
  endtask

  // Waits for the result; optionally drives junk strobes while busy.
  task automatic run(input string nm, input int em, input int ei, input int lat_max,
                     input bit junk);
    int n;
    bit got;
    bit busy_ok;
    n = 0; got = 0; busy_ok = 1;
    while (!got && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (bus.valid) got = 1;
      else if (!bus.busy) busy_ok = 0;
      if (junk && !got && n <= 4) begin
        bus.chardata  = 8'h78;
        bus.isstring  = 1'b1;
        bus.ispattern = 1'b1;
      end else begin
        idle_inputs();
      end
    end
    chk({nm, " valid_seen"}, int'(got), 1);
    chk({nm, " match"}, int'(bus.match), em);
    chk({nm, " index"}, int'(bus.match_index), ei);
    chk({nm, " busy_before_valid"}, int'(busy_ok), 1);
    chk({nm, " busy_at_valid"}, int'(bus.busy), 0);
    chk({nm, " latency_ok"}, int'(n <= lat_max), 1);
    @(posedge clk); #1;
    chk({nm, " valid_one_cycle"}, int'(bus.valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{96'("hello world"), 64'("wor"),  1'b0, 1, 6, 48};
    vt[1] = '{96'(0),             64'("^wor"), 1'b0, 1, 6, 48};
    vt[2] = '{96'(0),             64'("lo$"),  1'b0, 1, 3, 43};
    vt[3] = '{96'(0),             64'("rl$"),  1'b0, 0, 0, 43};
    vt[4] = '{96'(0),             64'("o.w"),  1'b0, 1, 4, 48};
    vt[5] = '{96'("AbCd"),        64'("bcd$"), 1'b1, 1, 1, 13};
    vt[6] = '{96'(0),             64'("bcd$"), 1'b0, 0, 0, 13};
    vt[7] = '{96'("ab"),          64'("abc"),  1'b0, 0, 0, 4};
    vt[8] = '{96'(0),             64'("^"),    1'b0, 1, 0, 9};
    vt[9] = '{96'(0),             64'("$"),    1'b0, 1, 2, 9};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset valid", int'(bus.valid), 0);
    chk("reset match", int'(bus.match), 0);
    chk("reset index", int'(bus.match_index), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      if (vt[i].s != 96'(0)) send(vt[i].s, 1'b1, 1'b0);
      send(96'(vt[i].p), 1'b0, vt[i].nc);
      run($sformatf("vec%0d", i), vt[i].em, vt[i].ei, vt[i].lat, 1'b0);
    end

    // Strobes during the search must leave string and pattern untouched.
    send(96'("hello world"), 1'b1, 1'b0);
    send(96'("wor"), 1'b0, 1'b0);
    run("busy_ignore", 1, 6, 48, 1'b1);
    send(96'("wor"), 1'b0, 1'b0);
    run("busy_ignore_after", 1, 6, 48, 1'b0);

    // 40 characters into a 32-entry string: length saturates at 32.
    for (int i = 0; i < 40; i++) begin
      bus.chardata = 8'h61;
      bus.isstring = 1'b1;
      @(posedge clk); #1;
    end
    idle_inputs();
    send(96'("aab"), 1'b0, 1'b0);
    run("sat_aab", 0, 0, 153, 1'b0);
    send(96'("a$"), 1'b0, 1'b0);
    run("sat_tail", 1, 31, 99, 1'b0);

    // Reset three cycles into a search.
    send(96'("hello world"), 1'b1, 1'b0);
    send(96'("wor"), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_search busy", int'(bus.busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_reset busy", int'(bus.busy), 0);
    chk("mid_reset valid", int'(bus.valid), 0);
    chk("mid_reset match", int'(bus.match), 0);
    chk("mid_reset index", int'(bus.match_index), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    begin
      bit saw_valid;
      saw_valid = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (bus.valid || bus.busy) saw_valid = 1;
      end
      chk("no_valid_after_reset", int'(saw_valid), 0);
    end
    send(96'("^"), 1'b0, 1'b0);
    run("empty_string", 0, 0, 4, 1'b0);
    send(96'("hello world"), 1'b1, 1'b0);
    send(96'("wor"), 1'b0, 1'b0);
    run("reload_after_reset", 1, 6, 48, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
